writebacker: RTL and testbench

WRITEBACKER -- requirements
Module: writebacker

---
 rtl/def.sv | 14 +
 rtl/scoreboarder.sv | 79 +++++++
 rtl/writebacker.sv | 77 +++++++
 tb/tb_writebacker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/def.sv
// Shared definitions for the register file / writeback block.
// Data width, register count and the register address type.
package def;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [1:0]    pend_t;

    localparam pend_t PEND_MAX = 2'd3;

endpackage

// File: rtl/scoreboarder.sv
// Per-register pending-write counters and issue hazard detection.
// Also tracks orphan writebacks in a sticky error flag.
module scoreboarder
    import def::*;
#(
    parameter int NREG = def::NREG
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_issue_valid,
    input  reg_addr_t i_rs1,
    input  reg_addr_t i_rs2,
    input  reg_addr_t i_rd,
    input  logic      i_we,
    input  logic      i_wb_valid,
    input  reg_addr_t i_wb_rd,
    input  logic      i_flush,
    output logic      o_ready,
    output logic      o_wb_err
);

    pend_t r_pend [NREG];
    pend_t w_nxt  [NREG];
    logic  r_wb_err;

    logic w_rs1_ok;
    logic w_rs2_ok;
    logic w_rd_ok;
    logic w_wb_hit;
    logic w_inc;
    logic w_dec;
    logic w_orphan;

    assign w_wb_hit = i_wb_valid && (i_wb_rd != '0);

    // A source with one outstanding write is fine if that write lands now.
    assign w_rs1_ok = (i_rs1 == '0) || (r_pend[i_rs1] == 2'd0) ||
                      ((r_pend[i_rs1] == 2'd1) && w_wb_hit &&
                       (i_wb_rd == i_rs1));
    assign w_rs2_ok = (i_rs2 == '0) || (r_pend[i_rs2] == 2'd0) ||
                      ((r_pend[i_rs2] == 2'd1) && w_wb_hit &&
                       (i_wb_rd == i_rs2));
    assign w_rd_ok  = !i_we || (i_rd == '0) || (r_pend[i_rd] != PEND_MAX);

    assign o_ready  = w_rs1_ok && w_rs2_ok && w_rd_ok && !i_flush;

    assign w_inc    = i_issue_valid && o_ready && i_we && (i_rd != '0);
    assign w_dec    = w_wb_hit && (r_pend[i_wb_rd] != 2'd0);
    assign w_orphan = w_wb_hit && (r_pend[i_wb_rd] == 2'd0);

    always_comb begin
        w_nxt = r_pend;
        if (w_inc) begin
            w_nxt[i_rd] = w_nxt[i_rd] + 2'd1;
        end
        if (w_dec) begin
            w_nxt[i_wb_rd] = w_nxt[i_wb_rd] - 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_pend[i] <= '0;
            end
            r_wb_err <= 1'b0;
        end else begin
            if (w_orphan) begin
                r_wb_err <= 1'b1;
            end
            for (int i = 0; i < NREG; i++) begin
                r_pend[i] <= i_flush ? 2'd0 : w_nxt[i];
            end
        end
    end

    assign o_wb_err = r_wb_err;

endmodule

// File: rtl/writebacker.sv
// Architectural register file with writeback bypass and an
// issue scoreboard that stalls on pending source writes.
module writebacker
    import def::*;
#(
    parameter int XLEN = def::XLEN,
    parameter int NREG = def::NREG
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ISSUE_VALID,
    input  reg_addr_t       ISSUE_RS1,
    input  reg_addr_t       ISSUE_RS2,
    input  reg_addr_t       ISSUE_RD,
    input  logic            ISSUE_WE,
    output logic            ISSUE_READY,
    output logic [XLEN-1:0] RS1_VAL,
    output logic [XLEN-1:0] RS2_VAL,
    input  logic            WB_VALID,
    input  reg_addr_t       WB_RD,
    input  logic [XLEN-1:0] WB_DATA,
    input  logic            FLUSH,
    output logic            WB_ERR
);

    logic [XLEN-1:0] r_rf [NREG];
    logic            w_wb_we;

    assign w_wb_we = WB_VALID && (WB_RD != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_rf[WB_RD] <= WB_DATA;
        end
    end

    // x0 is hardwired; otherwise a same-cycle writeback wins.
    always_comb begin
        RS1_VAL = r_rf[ISSUE_RS1];
        if (ISSUE_RS1 == '0) begin
            RS1_VAL = '0;
        end else if (w_wb_we && (WB_RD == ISSUE_RS1)) begin
            RS1_VAL = WB_DATA;
        end
    end

    always_comb begin
        RS2_VAL = r_rf[ISSUE_RS2];
        if (ISSUE_RS2 == '0) begin
            RS2_VAL = '0;
        end else if (w_wb_we && (WB_RD == ISSUE_RS2)) begin
            RS2_VAL = WB_DATA;
        end
    end

    scoreboarder #(
        .NREG (NREG)
    ) u_sb (
        .i_clk         (CLK),
        .i_rst         (RST),
        .i_issue_valid (ISSUE_VALID),
        .i_rs1         (ISSUE_RS1),
        .i_rs2         (ISSUE_RS2),
        .i_rd          (ISSUE_RD),
        .i_we          (ISSUE_WE),
        .i_wb_valid    (WB_VALID),
        .i_wb_rd       (WB_RD),
        .i_flush       (FLUSH),
        .o_ready       (ISSUE_READY),
        .o_wb_err      (WB_ERR)
    );

endmodule

// File: tb/tb_writebacker.sv
// Bench for writebacker: directed vector table, then random
// traffic compared against a counter/array reference model.
module tb_writebacker;

    logic        clk;
    logic        rst;
    logic        iv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        ready;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        fl;
    logic        err;

    int total = 0;
    int bad   = 0;

    writebacker dut (
        .CLK         (clk),
        .RST         (rst),
        .ISSUE_VALID (iv),
        .ISSUE_RS1   (rs1),
        .ISSUE_RS2   (rs2),
        .ISSUE_RD    (rd),
        .ISSUE_WE    (we),
        .ISSUE_READY (ready),
        .RS1_VAL     (rs1_val),
        .RS2_VAL     (rs2_val),
        .WB_VALID    (wbv),
        .WB_RD       (wbrd),
        .WB_DATA     (wbd),
        .FLUSH       (fl),
        .WB_ERR      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        fl;
        logic        e_ready;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(
        input logic r, input logic v, input int s1, input int s2,
        input int d, input logic w, input logic bv, input int br,
        input logic [31:0] bd, input logic f, input logic er,
        input logic [31:0] e1, input logic [31:0] e2, input logic ee
    );
        vec_t t;
        t.rst = r; t.iv = v;
        t.rs1 = 5'(s1); t.rs2 = 5'(s2); t.rd = 5'(d); t.we = w;
        t.wbv = bv; t.wbrd = 5'(br); t.wbd = bd; t.fl = f;
        t.e_ready = er; t.e_rs1 = e1; t.e_rs2 = e2; t.e_err = ee;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; iv = t.iv; rs1 = t.rs1; rs2 = t.rs2;
        rd = t.rd; we = t.we; wbv = t.wbv; wbrd = t.wbrd;
        wbd = t.wbd; fl = t.fl;
    endtask

    // reference model state
    int          m_pend [32];
    logic [31:0] m_rf   [32];
    logic        m_err;

    function automatic logic src_ok(input logic [4:0] r);
        if (r == 0) return 1'b1;
        if (m_pend[r] == 0) return 1'b1;
        return (m_pend[r] == 1) && wbv && (wbrd == r);
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wbv && wbrd == r) return wbd;
        return m_rf[r];
    endfunction

    initial begin
        vec_t t;
        logic m_ready;
        int   old;

        t = row(1,0,0,0,0,0,0,0,0,0, 1,0,0,0);
        @(negedge clk); drive(t);
        @(negedge clk); drive(t);

        tbl.push_back(row(1,0,0,0,0,0,0,0,32'h0,0, 1,32'h0,32'h0,0));
        tbl.push_back(row(0,1,0,0,5,1,0,0,32'h0,0, 1,32'h0,32'h0,0));
        tbl.push_back(row(0,1,5,0,0,0,0,0,32'h0,0, 0,32'h0,32'h0,0));
        tbl.push_back(row(0,1,5,0,0,0,1,5,32'hDEADBEEF,0,
                          1,32'hDEADBEEF,32'h0,0));
        tbl.push_back(row(0,0,5,0,0,0,0,0,32'h0,0,
                          1,32'hDEADBEEF,32'h0,0));
        tbl.push_back(row(0,0,0,0,0,0,1,0,32'h1234,0, 1,32'h0,32'h0,0));
        tbl.push_back(row(0,0,0,5,0,0,0,0,32'h0,0,
                          1,32'h0,32'hDEADBEEF,0));
        tbl.push_back(row(0,1,0,0,7,1,0,0,32'h0,0, 1,32'h0,32'h0,0));
        tbl.push_back(row(0,1,0,0,7,1,0,0,32'h0,0, 1,32'h0,32'h0,0));
        tbl.push_back(row(0,1,0,0,7,1,0,0,32'h0,0, 1,32'h0,32'h0,0));
        tbl.push_back(row(0,1,0,0,7,1,0,0,32'h0,0, 0,32'h0,32'h0,0));
        tbl.push_back(row(0,1,0,0,7,1,1,7,32'h77,0, 0,32'h0,32'h0,0));
        tbl.push_back(row(0,1,0,0,7,1,0,0,32'h0,0, 1,32'h0,32'h0,0));
        tbl.push_back(row(0,1,9,0,0,0,1,9,32'h99,0, 1,32'h99,32'h0,0));
        tbl.push_back(row(0,0,9,0,0,0,0,0,32'h0,0, 1,32'h99,32'h0,1));
        tbl.push_back(row(0,1,0,0,3,1,0,0,32'h0,0, 1,32'h0,32'h0,1));
        tbl.push_back(row(0,1,0,0,3,1,0,0,32'h0,0, 1,32'h0,32'h0,1));
        tbl.push_back(row(0,1,0,0,4,1,0,0,32'h0,0, 1,32'h0,32'h0,1));
        tbl.push_back(row(0,1,3,0,0,0,0,0,32'h0,0, 0,32'h0,32'h0,1));
        tbl.push_back(row(0,1,0,0,0,0,1,4,32'h55,1, 0,32'h0,32'h0,1));
        tbl.push_back(row(0,1,7,4,0,0,0,0,32'h0,0,
                          1,32'h77,32'h55,1));
        tbl.push_back(row(0,1,3,0,7,1,0,0,32'h0,0, 1,32'h0,32'h0,1));
        tbl.push_back(row(1,0,4,0,0,0,0,0,32'h0,0, 1,32'h55,32'h0,1));
        tbl.push_back(row(0,0,4,7,0,0,0,0,32'h0,0, 1,32'h0,32'h0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d ready", i), 32'(ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d rs1", i), rs1_val, tbl[i].e_rs1);
            chk($sformatf("v%0d rs2", i), rs2_val, tbl[i].e_rs2);
            chk($sformatf("v%0d err", i), 32'(err), 32'(tbl[i].e_err));
        end

        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0;
            m_rf[i] = 32'h0;
        end
        m_err = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst  = (c == 0) || ($urandom % 97 == 0);
            fl   = ($urandom % 19 == 0);
            iv   = ($urandom % 4 != 0);
            rs1  = 5'($urandom_range(0, 7));
            rs2  = 5'($urandom_range(0, 7));
            rd   = 5'($urandom_range(0, 7));
            we   = ($urandom % 3 != 0);
            wbv  = ($urandom % 2 == 0);
            wbrd = 5'($urandom_range(0, 7));
            wbd  = $urandom;
            #1;
            m_ready = src_ok(rs1) && src_ok(rs2) && !fl &&
                      (!we || rd == 0 || m_pend[rd] < 3);
            if (c > 0) begin
                chk("rnd ready", 32'(ready), 32'(m_ready));
                chk("rnd rs1", rs1_val, src_val(rs1));
                chk("rnd rs2", rs2_val, src_val(rs2));
                chk("rnd err", 32'(err), 32'(m_err));
            end
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_pend[i] = 0;
                    m_rf[i] = 32'h0;
                end
                m_err = 1'b0;
            end else begin
                old = m_pend[wbrd];
                if (wbv && wbrd != 0) begin
                    m_rf[wbrd] = wbd;
                    if (old == 0) m_err = 1'b1;
                end
                if (fl) begin
                    for (int i = 0; i < 32; i++) m_pend[i] = 0;
                end else begin
                    if (iv && m_ready && we && rd != 0)
                        m_pend[rd] = m_pend[rd] + 1;
                    if (wbv && wbrd != 0 && old > 0)
                        m_pend[wbrd] = m_pend[wbrd] - 1;
                end
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
